// File: rtl/shift_word_receiver.sv
// ---------------------------------------------------------------------------
// shift_word_receiver
//
// Receive end of the 4-bit parallel-access shift-register link. It collects
// the MSB-first bit stream from the Q3 (or Q3not) tap, reassembles LENGTH-bit
// words and offers each finished word on a one-word output register guarded
// by a valid/ready handshake.
//
// Parameters:
//   LENGTH  word width in bits (>= 2)
//   INVERT  1 = SIN comes from the Q3not tap, so every bit is complemented
//
// Ports:
//   CP       clock, all state changes on the rising edge
//   MR       master reset, asynchronous, active-low
//   SIN      serial data, MSB first
//   SVALID   SIN carries a valid bit this cycle
//   FRAME    resync strobe, drops any partial word
//   DOUT     received word
//   DVALID   DOUT holds an unconsumed word
//   DREADY   consumer takes DOUT when DVALID & DREADY
//   OVF      sticky flag: a completed word had to be dropped
//   OVF_CLR  clears OVF
//   BUSY     a partial word is in progress
// ---------------------------------------------------------------------------
module shift_word_receiver #(
    parameter int LENGTH = 4,
    parameter int INVERT = 0
) (
    input  logic              CP,
    input  logic              MR,
    input  logic              SIN,
    input  logic              SVALID,
    input  logic              FRAME,
    output logic [LENGTH-1:0] DOUT,
    output logic              DVALID,
    input  logic              DREADY,
    output logic              OVF,
    input  logic              OVF_CLR,
    output logic              BUSY
);

    // The counter only has to reach LENGTH-1 before it wraps back to zero.
    localparam int CW = (LENGTH > 2) ? $clog2(LENGTH) : 1;
    localparam int SW = LENGTH - 1;
    localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);
    localparam logic INV = (INVERT != 0);

    // Only the first LENGTH-1 bits need storing; the last bit goes straight
    // into the assembled word on the completing edge.
    logic [SW-1:0]     shift_q;
    logic [CW-1:0]     count;
    logic              bit_in;
    logic [LENGTH-1:0] word;
    logic              accept;
    logic              complete;
    logic              load;
    logic              drop;

    // Decode of the current edge: captured bit, the word it would finish,
    // and whether a finished word fits into the output slot. A FRAME strobe
    // suppresses completion, so a word ending on a resync edge is discarded
    // without touching the output slot or the overflow flag.
    always_comb begin
        bit_in   = SIN ^ INV;
        word     = {shift_q, bit_in};
        accept   = DVALID & DREADY;
        complete = SVALID & ~FRAME & (count == LAST);
        load     = complete & (~DVALID | DREADY);
        drop     = complete & DVALID & ~DREADY;
    end

    // Shift register and bit counter. FRAME restarts the word, keeping the
    // bit captured on the same edge as the first bit of the new word.
    always_ff @(posedge CP or negedge MR) begin
        if (!MR) begin
            shift_q <= '0;
            count   <= '0;
        end else if (FRAME) begin
            if (SVALID) begin
                shift_q <= SW'(bit_in);
                count   <= CW'(1);
            end else begin
                shift_q <= '0;
                count   <= '0;
            end
        end else if (SVALID) begin
            shift_q <= word[SW-1:0];
            if (complete) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

    // Output slot. A load on the same edge as an accept keeps DVALID high
    // and replaces the word; an accept alone empties the slot but leaves
    // DOUT at its last value.
    always_ff @(posedge CP or negedge MR) begin
        if (!MR) begin
            DOUT   <= '0;
            DVALID <= 1'b0;
        end else if (load) begin
            DOUT   <= word;
            DVALID <= 1'b1;
        end else if (accept) begin
            DVALID <= 1'b0;
        end
    end

    // Sticky overflow; a drop on the same edge as a clear request wins.
    always_ff @(posedge CP or negedge MR) begin
        if (!MR) begin
            OVF <= 1'b0;
        end else if (drop) begin
            OVF <= 1'b1;
        end else if (OVF_CLR) begin
            OVF <= 1'b0;
        end
    end

    assign BUSY = (count != '0);

endmodule

// File: tb/tb_shift_word_receiver.sv
module tb_shift_word_receiver;

    logic       CP;
    logic       MR;
    logic       SIN;
    logic       SVALID;
    logic       FRAME;
    logic       DREADY;
    logic       OVF_CLR;
    logic [3:0] dout_n;
    logic       dvalid_n;
    logic       ovf_n;
    logic       busy_n;
    logic [3:0] dout_i;
    logic       dvalid_i;
    logic       ovf_i;
    logic       busy_i;

    int checks;
    int errors;

    // Reference model, one entry per instance (0: INVERT=0, 1: INVERT=1).
    // It keeps the received bits as an integer value plus a bit count.
    int         m_val [2];
    int         m_cnt [2];
    logic [3:0] m_dout [2];
    logic       m_dv [2];
    logic       m_ovf [2];

    shift_word_receiver #(.LENGTH(4), .INVERT(0)) dut (
        .CP(CP), .MR(MR), .SIN(SIN), .SVALID(SVALID), .FRAME(FRAME),
        .DOUT(dout_n), .DVALID(dvalid_n), .DREADY(DREADY),
        .OVF(ovf_n), .OVF_CLR(OVF_CLR), .BUSY(busy_n)
    );

    shift_word_receiver #(.LENGTH(4), .INVERT(1)) dut_inv (
        .CP(CP), .MR(MR), .SIN(SIN), .SVALID(SVALID), .FRAME(FRAME),
        .DOUT(dout_i), .DVALID(dvalid_i), .DREADY(DREADY),
        .OVF(ovf_i), .OVF_CLR(OVF_CLR), .BUSY(busy_i)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_val[k] = 0; m_cnt[k] = 0; m_dout[k] = 4'h0; m_dv[k] = 1'b0; m_ovf[k] = 1'b0;
        end
    endtask

    // One rising edge of the reference: bits are counted; the fourth bit
    // yields a word that either goes to the slot or is lost as overflow.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int  b;
            bit  accept;
            bit  loaded;
            bit  dropped;
            b       = (SIN ^ (k == 1)) ? 1 : 0;
            accept  = m_dv[k] && DREADY;
            loaded  = 1'b0;
            dropped = 1'b0;
            if (FRAME) begin
                m_val[k] = SVALID ? b : 0;
                m_cnt[k] = SVALID ? 1 : 0;
            end else if (SVALID) begin
                m_val[k] = (m_val[k] * 2 + b) % 16;
                m_cnt[k] = m_cnt[k] + 1;
                if (m_cnt[k] == 4) begin
                    m_cnt[k] = 0;
                    if (!m_dv[k] || accept) begin
                        m_dout[k] = 4'(m_val[k]);
                        loaded    = 1'b1;
                    end else begin
                        dropped = 1'b1;
                    end
                    m_val[k] = 0;
                end
            end
            if (loaded) m_dv[k] = 1'b1;
            else if (accept) m_dv[k] = 1'b0;
            if (dropped) m_ovf[k] = 1'b1;
            else if (OVF_CLR) m_ovf[k] = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, clock it, and return at the falling edge
    // where outputs are sampled.
    task automatic applyStimulus(input logic sin, input logic sv, input logic fr,
                                 input logic rdy, input logic clr);
        SIN = sin; SVALID = sv; FRAME = fr; DREADY = rdy; OVF_CLR = clr;
        @(posedge CP);
        model_step();
        @(negedge CP);
    endtask

    task automatic reset_dut();
        @(negedge CP);
        SIN = 0; SVALID = 0; FRAME = 0; DREADY = 0; OVF_CLR = 0;
        MR = 1'b0;
        model_reset();
        @(negedge CP);
        MR = 1'b1;
        @(negedge CP);
    endtask

    task automatic send_word(input logic [3:0] w, input logic rdy_last);
        logic [3:0] v;
        v = w;
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(v[i], 1'b1, 1'b0, (i == 0) ? rdy_last : 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        MR = 1'b0; SIN = 0; SVALID = 0; FRAME = 0; DREADY = 0; OVF_CLR = 0;
        model_reset();
        #13;
        MR = 1'b1;
        @(negedge CP);
        checks++; if (dout_n !== 4'h0) begin errors++; $display("[TB] FAIL reset_dout got %h expected 0", dout_n); end
        checks++; if (dvalid_n !== 1'b0) begin errors++; $display("[TB] FAIL reset_dvalid got %b expected 0", dvalid_n); end
        checks++; if (ovf_n !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %b expected 0", ovf_n); end
        checks++; if (busy_n !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy_n); end
    endtask

    task automatic test_basic_word();
        reset_dut();
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checks++; if (busy_n !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_mid got %b expected 1", busy_n); end
        applyStimulus(1, 1, 0, 0, 0);
        checks++; if (dvalid_n !== 1'b0) begin errors++; $display("[TB] FAIL basic_dvalid_early got %b expected 0", dvalid_n); end
        applyStimulus(1, 1, 0, 0, 0);
        checks++; if (dout_n !== 4'hB) begin errors++; $display("[TB] FAIL basic_dout got %h expected B", dout_n); end
        checks++; if (dvalid_n !== 1'b1) begin errors++; $display("[TB] FAIL basic_dvalid got %b expected 1", dvalid_n); end
        checks++; if (busy_n !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_end got %b expected 0", busy_n); end
        applyStimulus(0, 0, 0, 1, 0);
        checks++; if (dvalid_n !== 1'b0) begin errors++; $display("[TB] FAIL basic_accept_dvalid got %b expected 0", dvalid_n); end
        checks++; if (dout_n !== 4'hB) begin errors++; $display("[TB] FAIL basic_accept_dout got %h expected B", dout_n); end
    endtask

    task automatic test_overflow();
        reset_dut();
        send_word(4'h3, 1'b0);
        checks++; if (ovf_n !== 1'b0) begin errors++; $display("[TB] FAIL ovf_before got %b expected 0", ovf_n); end
        send_word(4'hC, 1'b0);
        checks++; if (dout_n !== 4'h3) begin errors++; $display("[TB] FAIL ovf_dout got %h expected 3", dout_n); end
        checks++; if (ovf_n !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set got %b expected 1", ovf_n); end
        applyStimulus(0, 0, 0, 0, 1);
        checks++; if (ovf_n !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear got %b expected 0", ovf_n); end
        checks++; if (dvalid_n !== 1'b1) begin errors++; $display("[TB] FAIL ovf_dvalid_held got %b expected 1", dvalid_n); end
    endtask

    task automatic test_frame();
        reset_dut();
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checks++; if (dout_n !== 4'h6) begin errors++; $display("[TB] FAIL frame_dout got %h expected 6", dout_n); end
        checks++; if (dvalid_n !== 1'b1) begin errors++; $display("[TB] FAIL frame_dvalid got %b expected 1", dvalid_n); end
        // Three bits, then FRAME with a bit on the would-be completing edge.
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0);
        checks++; if (dout_n !== 4'h6) begin errors++; $display("[TB] FAIL frame_nocomplete_dout got %h expected 6", dout_n); end
        checks++; if (ovf_n !== 1'b0) begin errors++; $display("[TB] FAIL frame_nocomplete_ovf got %b expected 0", ovf_n); end
        checks++; if (busy_n !== 1'b1) begin errors++; $display("[TB] FAIL frame_restart_busy got %b expected 1", busy_n); end
        applyStimulus(0, 0, 1, 0, 0);
        checks++; if (busy_n !== 1'b0) begin errors++; $display("[TB] FAIL frame_idle_busy got %b expected 0", busy_n); end
    endtask

    task automatic test_invert();
        reset_dut();
        send_word(4'h4, 1'b0);
        checks++; if (dout_i !== 4'hB) begin errors++; $display("[TB] FAIL invert_dout got %h expected B", dout_i); end
        checks++; if (dvalid_i !== 1'b1) begin errors++; $display("[TB] FAIL invert_dvalid got %b expected 1", dvalid_i); end
        checks++; if (dout_n !== 4'h4) begin errors++; $display("[TB] FAIL plain_dout got %h expected 4", dout_n); end
    endtask

    task automatic test_accept_and_load();
        reset_dut();
        send_word(4'h3, 1'b0);
        send_word(4'h5, 1'b1);
        checks++; if (dout_n !== 4'h5) begin errors++; $display("[TB] FAIL swap_dout got %h expected 5", dout_n); end
        checks++; if (dvalid_n !== 1'b1) begin errors++; $display("[TB] FAIL swap_dvalid got %b expected 1", dvalid_n); end
        checks++; if (ovf_n !== 1'b0) begin errors++; $display("[TB] FAIL swap_ovf got %b expected 0", ovf_n); end
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        #2;
        MR = 1'b0;
        #1;
        checks++; if (dout_n !== 4'h0) begin errors++; $display("[TB] FAIL mr_dout got %h expected 0", dout_n); end
        checks++; if (dvalid_n !== 1'b0) begin errors++; $display("[TB] FAIL mr_dvalid got %b expected 0", dvalid_n); end
        checks++; if (busy_n !== 1'b0) begin errors++; $display("[TB] FAIL mr_busy got %b expected 0", busy_n); end
        checks++; if (ovf_n !== 1'b0) begin errors++; $display("[TB] FAIL mr_ovf got %b expected 0", ovf_n); end
        model_reset();
        @(negedge CP);
        MR = 1'b1;
        @(negedge CP);
    endtask

    task automatic test_back_to_back();
        logic [3:0] w;
        reset_dut();
        for (int n = 0; n < 6; n++) begin
            w = 4'($urandom_range(0, 15));
            for (int i = 3; i >= 0; i--) begin
                applyStimulus(w[i], 1'b1, 1'b0, 1'b1, 1'b0);
            end
            checks++; if (dout_n !== w) begin errors++; $display("[TB] FAIL b2b_dout got %h expected %h", dout_n, w); end
            checks++; if (dvalid_n !== 1'b1) begin errors++; $display("[TB] FAIL b2b_dvalid got %b expected 1", dvalid_n); end
        end
        checks++; if (ovf_n !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ovf got %b expected 0", ovf_n); end
    endtask

    task automatic test_random();
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 9) < 8),
                          1'($urandom_range(0, 29) == 0),
                          1'($urandom_range(0, 2) == 0),
                          1'($urandom_range(0, 19) == 0));
            checks++; if (dout_n !== m_dout[0]) begin errors++; $display("[TB] FAIL rand_dout cycle %0d got %h expected %h", c, dout_n, m_dout[0]); end
            checks++; if (dvalid_n !== m_dv[0]) begin errors++; $display("[TB] FAIL rand_dvalid cycle %0d got %b expected %b", c, dvalid_n, m_dv[0]); end
            checks++; if (ovf_n !== m_ovf[0]) begin errors++; $display("[TB] FAIL rand_ovf cycle %0d got %b expected %b", c, ovf_n, m_ovf[0]); end
            checks++; if (busy_n !== (m_cnt[0] != 0)) begin errors++; $display("[TB] FAIL rand_busy cycle %0d got %b expected %b", c, busy_n, (m_cnt[0] != 0)); end
            checks++; if (dout_i !== m_dout[1]) begin errors++; $display("[TB] FAIL rand_inv_dout cycle %0d got %h expected %h", c, dout_i, m_dout[1]); end
            checks++; if (dvalid_i !== m_dv[1]) begin errors++; $display("[TB] FAIL rand_inv_dvalid cycle %0d got %b expected %b", c, dvalid_i, m_dv[1]); end
            checks++; if (ovf_i !== m_ovf[1]) begin errors++; $display("[TB] FAIL rand_inv_ovf cycle %0d got %b expected %b", c, ovf_i, m_ovf[1]); end
            checks++; if (busy_i !== (m_cnt[1] != 0)) begin errors++; $display("[TB] FAIL rand_inv_busy cycle %0d got %b expected %b", c, busy_i, (m_cnt[1] != 0)); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_word();
        test_overflow();
        test_frame();
        test_invert();
        test_accept_and_load();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
